// File: rtl/sd_bd_queue.sv
// Buffer-descriptor queue: host writes 2-word descriptors over Wishbone and the
// data master reads them word by word with a re/ack handshake, then frees the slot with a_cmp.
module sd_bd_queue #(
   parameter int BD_DEPTH = 8,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   input  logic             wb_we_i,
   input  logic [31:0]      wb_dat_i,
   output logic [31:0]      wb_dat_o,
   output logic             wb_ack_o,
   input  logic             bd_clr,
   input  logic             re,
   output logic             ack,
   output logic [31:0]      dat_out,
   input  logic             a_cmp,
   output logic [CNT_W-1:0] free_bd,
   output logic             bd_ovf,
   output logic             bd_err
);

   localparam int AW = $clog2(2 * BD_DEPTH);

   typedef enum logic [1:0] {R_IDLE, R_ACK, R_GAP} rd_state_t;

   logic [31:0]      r_mem [2*BD_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic             r_wr_phase;
   logic             r_rd_phase;
   logic [CNT_W-1:0] r_free_bd;
   logic [CNT_W-1:0] r_pend_bd;
   logic             r_ovf;
   logic             r_err;
   logic             r_wb_ack;
   logic             r_ack;
   logic             r_a_cmp_q;
   logic [31:0]      r_dat_out;
   rd_state_t        r_rd_state;

   logic             w_wb_req;
   logic             w_wr_req;
   logic             w_wr_accept;
   logic             w_wr_drop;
   logic             w_commit;
   logic             w_rd_start;
   logic             w_rd_done;
   logic             w_cmp_edge;
   logic             w_cmp_ok;
   logic             w_cmp_bad;
   logic [CNT_W:0]   w_in_flight;

   assign w_wb_req    = wb_cyc_i & wb_stb_i & ~r_wb_ack;
   assign w_wr_req    = w_wb_req & wb_we_i;
   // A half-written descriptor is always completed, even when no slot is free.
   assign w_wr_accept = w_wr_req & ((r_free_bd != '0) | r_wr_phase);
   assign w_wr_drop   = w_wr_req & ~w_wr_accept;
   assign w_commit    = w_wr_accept & r_wr_phase;

   assign w_rd_start  = (r_rd_state == R_IDLE) & re & ((r_pend_bd != '0) | r_rd_phase);
   assign w_rd_done   = w_rd_start & r_rd_phase;

   assign w_in_flight = (CNT_W+1)'(BD_DEPTH) - {1'b0, r_free_bd} - {1'b0, r_pend_bd};
   assign w_cmp_edge  = a_cmp & ~r_a_cmp_q;
   assign w_cmp_ok    = w_cmp_edge & (w_in_flight != '0);
   assign w_cmp_bad   = w_cmp_edge & (w_in_flight == '0);

   // NOTE: descriptor storage has no reset; every word is written before the read side may reach it.
   always_ff @(posedge clk) begin
      if (w_wr_accept && !bd_clr)
         r_mem[r_wr_ptr] <= wb_dat_i;
   end

   // Wishbone write side
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_ack   <= 1'b0;
         r_wr_ptr   <= '0;
         r_wr_phase <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (bd_clr) begin
         r_wb_ack   <= 1'b0;
         r_wr_ptr   <= '0;
         r_wr_phase <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_wb_ack <= w_wb_req;
         if (w_wr_accept) begin
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_wr_phase <= ~r_wr_phase;
         end
         if (w_wr_drop)
            r_ovf <= 1'b1;
      end
   end

   // Read FSM: ack, dat_out and the read pointer all update on entry to R_ACK
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_state <= R_IDLE;
         r_rd_ptr   <= '0;
         r_rd_phase <= 1'b0;
         r_ack      <= 1'b0;
         r_dat_out  <= '0;
      end else if (bd_clr) begin
         r_rd_state <= R_IDLE;
         r_rd_ptr   <= '0;
         r_rd_phase <= 1'b0;
         r_ack      <= 1'b0;
         r_dat_out  <= '0;
      end else begin
         case (r_rd_state)
            R_IDLE: begin
               if (w_rd_start) begin
                  r_ack      <= 1'b1;
                  r_dat_out  <= r_mem[r_rd_ptr];
                  r_rd_ptr   <= r_rd_ptr + AW'(1);
                  r_rd_phase <= ~r_rd_phase;
                  r_rd_state <= R_ACK;
               end
            end
            R_ACK: begin
               r_ack      <= 1'b0;
               r_rd_state <= R_GAP;
            end
            R_GAP:   r_rd_state <= R_IDLE;
            default: r_rd_state <= R_IDLE;
         endcase
      end
   end

   // Slot accounting; simultaneous +1/-1 events cancel out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_free_bd <= CNT_W'(BD_DEPTH);
         r_pend_bd <= '0;
         r_err     <= 1'b0;
         r_a_cmp_q <= 1'b0;
      end else begin
         r_a_cmp_q <= a_cmp;
         if (bd_clr) begin
            r_free_bd <= CNT_W'(BD_DEPTH);
            r_pend_bd <= '0;
            r_err     <= 1'b0;
         end else begin
            case ({w_commit, w_cmp_ok})
               2'b10:   r_free_bd <= r_free_bd - CNT_W'(1);
               2'b01:   r_free_bd <= r_free_bd + CNT_W'(1);
               default: r_free_bd <= r_free_bd;
            endcase
            case ({w_commit, w_rd_done})
               2'b10:   r_pend_bd <= r_pend_bd + CNT_W'(1);
               2'b01:   r_pend_bd <= r_pend_bd - CNT_W'(1);
               default: r_pend_bd <= r_pend_bd;
            endcase
            if (w_cmp_bad)
               r_err <= 1'b1;
         end
      end
   end

   assign wb_ack_o = r_wb_ack;
   assign wb_dat_o = 32'({r_free_bd, r_pend_bd, r_ovf, r_err});
   assign ack      = r_ack;
   assign dat_out  = r_dat_out;
   assign free_bd  = r_free_bd;
   assign bd_ovf   = r_ovf;
   assign bd_err   = r_err;

endmodule

// File: tb/tb_sd_bd_queue.sv
// Directed bench for sd_bd_queue: Wishbone descriptor writes, re/ack reads,
// a_cmp completion, overflow, wrap, simultaneous commit/complete, bd_clr and async reset.
module tb_sd_bd_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic        wb_we_i = 1'b0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        bd_clr = 1'b0;
   logic        re = 1'b0;
   logic        ack;
   logic [31:0] dat_out;
   logic        a_cmp = 1'b0;
   logic [3:0]  free_bd;
   logic        bd_ovf;
   logic        bd_err;

   int          n_pass = 0;
   int          n_total = 0;
   int          cyc_cnt = 0;
   logic [31:0] acks_q[$];
   int          ack_cyc_q[$];

   sd_bd_queue #(.BD_DEPTH(8), .CNT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_we_i  (wb_we_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .bd_clr   (bd_clr),
      .re       (re),
      .ack      (ack),
      .dat_out  (dat_out),
      .a_cmp    (a_cmp),
      .free_bd  (free_bd),
      .bd_ovf   (bd_ovf),
      .bd_err   (bd_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt++;

   // Record every data-master word; sampled on the falling edge
   always @(negedge clk) begin
      if (ack === 1'b1) begin
         acks_q.push_back(dat_out);
         ack_cyc_q.push_back(cyc_cnt);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] status(input int free, input int pend, input bit ovf, input bit err);
      return (32'(free) << 6) | (32'(pend) << 2) | (32'(ovf) << 1) | 32'(err);
   endfunction

   task automatic wb_cycle(input logic we, input logic [31:0] d, output logic [31:0] rd);
      bit got = 1'b0;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_dat_i = d;
      rd = '0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (wb_ack_o === 1'b1) begin
            got = 1'b1;
            rd  = wb_dat_o;
            break;
         end
      end
      if (!got) check("wb_ack_timeout", 32'(got), 32'd1);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wb_write(input logic [31:0] d);
      logic [31:0] unused;
      wb_cycle(1'b1, d, unused);
   endtask

   task automatic wb_read(output logic [31:0] d);
      wb_cycle(1'b0, '0, d);
   endtask

   task automatic wait_acks(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && acks_q.size() < n; i++)
         @(negedge clk);
      check(tag, 32'(acks_q.size()), 32'(n));
   endtask

   task automatic pulse_cmp();
      a_cmp = 1'b1;
      @(negedge clk);
      a_cmp = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_clr();
      bd_clr = 1'b1;
      @(negedge clk);
      bd_clr = 1'b0;
      @(negedge clk);
   endtask

   logic [31:0] st;

   initial begin
      // 1. reset, re held high with nothing queued
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_free", 32'(free_bd), 32'd8);
      rst = 1'b0;
      re  = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_no_ack", 32'(acks_q.size()), 32'd0);
      wb_read(st);
      check("idle_status", st, status(8, 0, 0, 0));

      // 2. one descriptor, re held: two acks 3 cycles apart, no third
      wb_write(32'h1000_0000);
      check("s2_free_w0", 32'(free_bd), 32'd8);
      wb_write(32'h0000_0200);
      wait_acks("s2_ack_count", 2, 20);
      repeat (10) @(negedge clk);
      check("s2_no_third_ack", 32'(acks_q.size()), 32'd2);
      check("s2_word0", acks_q[0], 32'h1000_0000);
      check("s2_word1", acks_q[1], 32'h0000_0200);
      check("s2_ack_spacing", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'd3);
      check("s2_free", 32'(free_bd), 32'd7);
      re = 1'b0;
      acks_q.delete();
      ack_cyc_q.delete();

      // 3. a_cmp held two cycles frees exactly one slot
      a_cmp = 1'b1;
      repeat (2) @(negedge clk);
      a_cmp = 1'b0;
      repeat (2) @(negedge clk);
      check("s3_free", 32'(free_bd), 32'd8);
      check("s3_err", 32'(bd_err), 32'd0);

      // 4. fill, overflow, drain with wrap, 10th descriptor from slot 0
      pulse_clr();
      for (int i = 0; i < 8; i++) begin
         wb_write(32'hD000_0000 + 32'(i));
         wb_write(32'h0000_0100 + 32'(i));
      end
      check("s4_free_full", 32'(free_bd), 32'd0);
      wb_write(32'hDEAD_0008);
      wb_write(32'hDEAD_0108);
      wb_read(st);
      check("s4_status_ovf", st, status(0, 8, 1, 0));
      re = 1'b1;
      wait_acks("s4_drain_count", 16, 120);
      re = 1'b0;
      repeat (4) @(negedge clk);
      check("s4_no_extra", 32'(acks_q.size()), 32'd16);
      for (int i = 0; i < 8; i++) begin
         check("s4_drain_w0", acks_q[2*i],   32'hD000_0000 + 32'(i));
         check("s4_drain_w1", acks_q[2*i+1], 32'h0000_0100 + 32'(i));
      end
      for (int i = 0; i < 8; i++) pulse_cmp();
      check("s4_free_back", 32'(free_bd), 32'd8);
      check("s4_err", 32'(bd_err), 32'd0);
      acks_q.delete();
      ack_cyc_q.delete();
      wb_write(32'hA0A0_0010);
      wb_write(32'h0000_0A10);
      re = 1'b1;
      wait_acks("s4_tenth_count", 2, 20);
      re = 1'b0;
      check("s4_tenth_w0", acks_q[0], 32'hA0A0_0010);
      check("s4_tenth_w1", acks_q[1], 32'h0000_0A10);
      pulse_cmp();
      check("s4_ovf_sticky", 32'(bd_ovf), 32'd1);

      // 5. commit of B in the same cycle as completion of A
      pulse_clr();
      check("s5_clr_ovf", 32'(bd_ovf), 32'd0);
      acks_q.delete();
      ack_cyc_q.delete();
      wb_write(32'hAAAA_0000);
      wb_write(32'hAAAA_0001);
      re = 1'b1;
      wait_acks("s5_a_count", 2, 20);
      re = 1'b0;
      check("s5_free_a", 32'(free_bd), 32'd7);
      wb_write(32'hBBBB_0000);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = 1'b1;
      wb_dat_i = 32'hBBBB_0001;
      a_cmp    = 1'b1;
      @(posedge clk);
      #1;
      check("s5_wb_ack", 32'(wb_ack_o), 32'd1);
      check("s5_free_same_cycle", 32'(free_bd), 32'd7);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      @(negedge clk);
      a_cmp = 1'b0;
      @(negedge clk);
      wb_read(st);
      check("s5_status", st, status(7, 1, 0, 0));
      acks_q.delete();
      ack_cyc_q.delete();
      re = 1'b1;
      wait_acks("s5_b_count", 2, 20);
      re = 1'b0;
      check("s5_b_w1", acks_q[1], 32'hBBBB_0001);
      pulse_cmp();
      check("s5_free_end", 32'(free_bd), 32'd8);

      // 6. bd_clr after word 0, then async reset after word 0
      acks_q.delete();
      ack_cyc_q.delete();
      wb_write(32'hCCCC_0000);
      wb_write(32'hCCCC_0001);
      re = 1'b1;
      wait_acks("s6_c_w0_count", 1, 20);
      re = 1'b0;
      repeat (4) @(negedge clk);
      check("s6_hold_phase", 32'(acks_q.size()), 32'd1);
      pulse_clr();
      wb_read(st);
      check("s6_clr_status", st, status(8, 0, 0, 0));
      acks_q.delete();
      ack_cyc_q.delete();
      wb_write(32'hDDDD_0000);
      wb_write(32'hDDDD_0001);
      re = 1'b1;
      wait_acks("s6_d_count", 2, 20);
      re = 1'b0;
      check("s6_d_w0", acks_q[0], 32'hDDDD_0000);
      check("s6_d_w1", acks_q[1], 32'hDDDD_0001);

      acks_q.delete();
      ack_cyc_q.delete();
      wb_write(32'hEEEE_0000);
      wb_write(32'hEEEE_0001);
      re = 1'b1;
      wait_acks("s6_e_w0_count", 1, 20);
      re = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #2;
      check("s6_rst_free", 32'(free_bd), 32'd8);
      check("s6_rst_ack", 32'(ack), 32'd0);
      check("s6_rst_dat", dat_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wb_read(st);
      check("s6_rst_status", st, status(8, 0, 0, 0));
      acks_q.delete();
      ack_cyc_q.delete();
      wb_write(32'hF0F0_0000);
      wb_write(32'hF0F0_0001);
      re = 1'b1;
      wait_acks("s6_f_count", 2, 20);
      re = 1'b0;
      check("s6_f_w0", acks_q[0], 32'hF0F0_0000);
      check("s6_f_w1", acks_q[1], 32'hF0F0_0001);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
